uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_arb_pkg.sv | 17 +
 rtl/uart_tx_arbiter_rr_picker.sv | 30 +++
 rtl/uart_tx_arbiter.sv | 153 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Purpose: shared types and default constants for the UART transmit arbiter.
// Latency: none (declarations only).
// Backpressure: n/a.
package uart_arb_pkg;

  localparam int NREQ_DEF    = 4;
  localparam int TIMEOUT_DEF = 1024;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    START,
    WAIT_HI,
    WAIT_LO
  } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Purpose: round-robin picker, first asserted request at or after ptr_i (wrapping).
// Latency: purely combinational.
// Backpressure: n/a; any_o low means no request to grant.
module rr_picker #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [IW-1:0]   grant_o,
  output logic            any_o
);

  // Scan from the farthest offset down to offset 0 so the closest request wins last.
  always_comb begin
    int idx;
    idx     = 0;
    grant_o = '0;
    any_o   = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(ptr_i) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req_i[IW'(idx)]) begin
        grant_o = IW'(idx);
        any_o   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Purpose: arbitrates NREQ byte streams onto one UART transmitter, holding the grant per message.
// Latency: req_valid in IDLE -> req_ready next cycle -> tx_start the cycle after the handshake.
// Backpressure: req_ready only in GRANT; next byte taken after tx_busy falls. UART_ARB_TIMEOUT_EN adds idle-owner release.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ-1:0][7:0]    req_data,
  input  logic [NREQ-1:0]         req_last,
  output logic [NREQ-1:0]         req_ready,
  output logic [7:0]              tx_data,
  output logic                    tx_start,
  input  logic                    tx_busy,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic                    locked,
  output logic                    timeout_evt
);

  localparam int IW = $clog2(NREQ);

  arb_state_t    state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic          locked_q, locked_d;
  logic          last_q, last_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic [IW-1:0] pick_idx;
  logic          pick_any;
  logic [IW-1:0] owner_nxt;

`ifdef UART_ARB_TIMEOUT_EN
  localparam logic [15:0] TMO_LIM = 16'(TIMEOUT - 1);
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic        tmo_evt_q, tmo_evt_d;
`endif

  rr_picker #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (pick_idx),
    .any_o   (pick_any)
  );

  assign owner_nxt = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + 1'b1;

  // Next-state and output decode; outputs other than the grant strobe are registered.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    locked_d  = locked_q;
    last_d    = last_q;
    tx_data_d = tx_data_q;
    req_ready = '0;
    tx_start  = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
    tmo_cnt_d = '0;
    tmo_evt_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          owner_d  = pick_idx;
          locked_d = 1'b1;
          state_d  = GRANT;
        end
      end
      GRANT: begin
        req_ready[owner_q] = 1'b1;
        if (req_valid[owner_q]) begin
          tx_data_d = req_data[owner_q];
          last_d    = req_last[owner_q];
          state_d   = START;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_LIM) begin
          rr_ptr_d  = owner_nxt;
          locked_d  = 1'b0;
          tmo_evt_d = 1'b1;
          state_d   = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
`endif
      end
      START: begin
        tx_start = 1'b1;
        state_d  = WAIT_HI;
      end
      WAIT_HI: begin
        if (tx_busy) state_d = WAIT_LO;
      end
      WAIT_LO: begin
        if (!tx_busy) begin
          if (last_q) begin
            rr_ptr_d = owner_nxt;
            locked_d = 1'b0;
            state_d  = IDLE;
          end else begin
            state_d = GRANT;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Arbiter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      rr_ptr_q  <= '0;
      locked_q  <= 1'b0;
      last_q    <= 1'b0;
      tx_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_ptr_q  <= rr_ptr_d;
      locked_q  <= locked_d;
      last_q    <= last_d;
      tx_data_q <= tx_data_d;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  // Idle-owner counter and the registered forced-release pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
      tmo_evt_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      tmo_evt_q <= tmo_evt_d;
    end
  end
  assign timeout_evt = tmo_evt_q;
`else
  // Legal TIMEOUT is 1..65535, so this is a constant 0 without the release feature.
  assign timeout_evt = (TIMEOUT == 0);
`endif

  assign owner   = owner_q;
  assign locked  = locked_q;
  assign tx_data = tx_data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Purpose: scoreboard bench for uart_tx_arbiter with per-requester byte sources and a UART busy model.
// Latency: checks IDLE->ready->start timing directly; tx_start order checked via expected queue.
// Backpressure: transmitter model holds tx_busy for BUSY cycles after each start.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;
  localparam int TMO  = 16;
  localparam int BUSY = 20;

  typedef struct packed {
    logic [1:0] own;
    logic [7:0] dat;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0][7:0] req_data;
  logic [NREQ-1:0]      req_last;
  logic [NREQ-1:0]      req_ready;
  logic [7:0]           tx_data;
  logic                 tx_start;
  logic                 tx_busy;
  logic [1:0]           owner;
  logic                 locked;
  logic                 timeout_evt;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q[$];
  logic [8:0] mem [NREQ][16];
  int   head [NREQ];
  int   tail [NREQ];

  uart_tx_arbiter #(.NREQ(NREQ), .TIMEOUT(TMO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_busy     (tx_busy),
    .owner       (owner),
    .locked      (locked),
    .timeout_evt (timeout_evt)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic enq(input int r, input logic [7:0] d, input logic l);
    mem[r][tail[r]] = {l, d};
    tail[r]++;
  endtask

  task automatic expect_tx(input logic [1:0] o, input logic [7:0] d);
    exp_t e;
    e.own = o;
    e.dat = d;
    exp_q.push_back(e);
  endtask

  task automatic refresh();
    for (int i = 0; i < NREQ; i++) begin
      if (head[i] < tail[i]) begin
        req_valid[i] = 1'b1;
        req_data[i]  = mem[i][head[i]][7:0];
        req_last[i]  = mem[i][head[i]][8];
      end else begin
        req_valid[i] = 1'b0;
        req_data[i]  = 8'h00;
        req_last[i]  = 1'b0;
      end
    end
  endtask

  task automatic flush();
    for (int i = 0; i < NREQ; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
  endtask

  function automatic logic pending();
    logic p;
    p = 1'b0;
    for (int i = 0; i < NREQ; i++) if (head[i] < tail[i]) p = 1'b1;
    return p;
  endfunction

  // Byte sources: record handshakes away from the edge, advance after the edge.
  initial begin : feeder
    logic [NREQ-1:0] hs;
    flush();
    refresh();
    forever begin
      @(negedge clk);
      hs = rst_n ? (req_valid & req_ready) : '0;
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) if (hs[i]) head[i]++;
      #1;
      refresh();
    end
  end

  // Transmitter model: busy rises the cycle after tx_start and stays for BUSY cycles.
  initial begin : txm
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && tx_start) begin
        @(posedge clk);
        #1 tx_busy = 1'b1;
        repeat (BUSY) @(posedge clk);
        #1 tx_busy = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard on every tx_start and checks flow-control invariants.
  initial begin : mon
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (req_ready != '0) chk("ready_while_busy", {31'd0, tx_busy}, 32'd0);
        if (tx_start) begin
          chk("start_while_busy", {31'd0, tx_busy}, 32'd0);
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_tx_start: got data 0x%0h owner %0d, expected no start", tx_data, owner);
          end else begin
            e = exp_q.pop_front();
            chk("tx_data", {24'd0, tx_data}, {24'd0, e.dat});
            chk("tx_owner", {30'd0, owner}, {30'd0, e.own});
          end
        end
      end
    end
  end

  task automatic drain(input string nm);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || locked || tx_busy || pending()) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_drain"}, {31'd0, (k < 2000)}, 32'd1);
  endtask

  task automatic check_reset_vals(input string nm);
    chk({nm, "_ready"},  {28'd0, req_ready}, 32'd0);
    chk({nm, "_start"},  {31'd0, tx_start}, 32'd0);
    chk({nm, "_locked"}, {31'd0, locked}, 32'd0);
    chk({nm, "_owner"},  {30'd0, owner}, 32'd0);
    chk({nm, "_txdata"}, {24'd0, tx_data}, 32'd0);
    chk({nm, "_tmo"},    {31'd0, timeout_evt}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    flush();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int k;
    int cnt;
    int evts;

    // Reset values.
    #2;
    check_reset_vals("rst0");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Message from req0 holds the grant while req1 waits.
    @(posedge clk);
    #1;
    enq(0, 8'h41, 1'b0); enq(0, 8'h42, 1'b0); enq(0, 8'h43, 1'b1);
    enq(1, 8'h55, 1'b1);
    expect_tx(2'd0, 8'h41); expect_tx(2'd0, 8'h42); expect_tx(2'd0, 8'h43);
    expect_tx(2'd1, 8'h55);
    drain("msg3");

    // All four single-byte requesters from rr_ptr 0: order 0,1,2,3,0.
    do_reset();
    @(posedge clk);
    #1;
    enq(0, 8'hA0, 1'b1); enq(0, 8'hA4, 1'b1);
    enq(1, 8'hA1, 1'b1); enq(2, 8'hA2, 1'b1); enq(3, 8'hA3, 1'b1);
    expect_tx(2'd0, 8'hA0); expect_tx(2'd1, 8'hA1); expect_tx(2'd2, 8'hA2);
    expect_tx(2'd3, 8'hA3); expect_tx(2'd0, 8'hA4);
    drain("rr4");

    // Req2 alone from IDLE: ready at cycle 1, tx_start at cycle 2.
    @(posedge clk);
    #1;
    enq(2, 8'hC5, 1'b1);
    expect_tx(2'd2, 8'hC5);
    @(negedge clk);
    chk("lat_c0_valid", {31'd0, req_valid[2]}, 32'd1);
    chk("lat_c0_ready", {28'd0, req_ready}, 32'd0);
    @(negedge clk);
    chk("lat_c1_ready", {28'd0, req_ready}, 32'h4);
    chk("lat_c1_start", {31'd0, tx_start}, 32'd0);
    @(negedge clk);
    chk("lat_c2_start", {31'd0, tx_start}, 32'd1);
    chk("lat_c2_data",  {24'd0, tx_data}, 32'hC5);
    drain("lat");

    // Single requester regranted after rr_ptr wraps past it.
    @(posedge clk);
    #1;
    enq(3, 8'h71, 1'b1); enq(3, 8'h72, 1'b1);
    expect_tx(2'd3, 8'h71); expect_tx(2'd3, 8'h72);
    drain("solo");

    // Owner goes quiet mid-message.
    do_reset();
    @(posedge clk);
    #1;
    enq(1, 8'h11, 1'b0);
    enq(3, 8'h33, 1'b1);
    expect_tx(2'd1, 8'h11);
`ifdef UART_ARB_TIMEOUT_EN
    expect_tx(2'd3, 8'h33);
`endif
    k = 0;
    while (!(req_ready[1] && !req_valid[1]) && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("idle_grant_seen", {31'd0, (k < 300)}, 32'd1);
`ifdef UART_ARB_TIMEOUT_EN
    cnt = 0;
    k = 0;
    while (!timeout_evt && k < 100) begin
      if (req_ready[1]) cnt++;
      @(negedge clk);
      k++;
    end
    chk("tmo_cycles", cnt, TMO);
    chk("tmo_evt", {31'd0, timeout_evt}, 32'd1);
    chk("tmo_locked", {31'd0, locked}, 32'd0);
    @(negedge clk);
    chk("tmo_pulse_len", {31'd0, timeout_evt}, 32'd0);
    drain("tmo");
`else
    evts = 0;
    repeat (100) begin
      @(negedge clk);
      if (timeout_evt) evts++;
    end
    chk("hold_evts", evts, 0);
    chk("hold_locked", {31'd0, locked}, 32'd1);
    chk("hold_owner", {30'd0, owner}, 32'd1);
    chk("hold_ready", {28'd0, req_ready}, 32'h2);
    @(posedge clk);
    #1;
    enq(1, 8'h12, 1'b1);
    expect_tx(2'd1, 8'h12);
    expect_tx(2'd3, 8'h33);
    drain("hold");
`endif

    // Reset during WAIT_LO drops the message.
    @(posedge clk);
    #1;
    enq(0, 8'h21, 1'b0); enq(0, 8'h22, 1'b1);
    expect_tx(2'd0, 8'h21);
    k = 0;
    while (!tx_busy && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("mid_busy_seen", {31'd0, (k < 200)}, 32'd1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_reset_vals("rst_mid");
    flush();
    chk("rst_exp_empty", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    while (tx_busy && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("post_rst_locked", {31'd0, locked}, 32'd0);
    @(posedge clk);
    #1;
    enq(2, 8'h5A, 1'b1);
    expect_tx(2'd2, 8'h5A);
    drain("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
